// File: rtl/avst_eth_framer_if.sv
// Avalon-ST bundle for the Ethernet framer.
// Carries the MAC addresses, the payload sink stream (data_i/empty_i/valid_i/
// sop_i/eop_i/ready_in_o), the framed source stream (data_o/empty_o/valid_o/
// sop_o/eop_o/ready_out_i) and the two status counters.
// slave  : the framer side.
// master : the side feeding payload in and draining frames out.
interface avst_eth_framer_if #(
   parameter int DATA_W = 32
);
   localparam int EMPTY_W = $clog2(DATA_W / 8);

   logic [47:0]         mac_src_i;
   logic [47:0]         mac_dst_i;
   logic [DATA_W-1:0]   data_i;
   logic [EMPTY_W-1:0]  empty_i;
   logic                valid_i;
   logic                sop_i;
   logic                eop_i;
   logic                ready_in_o;
   logic [DATA_W-1:0]   data_o;
   logic [EMPTY_W-1:0]  empty_o;
   logic                valid_o;
   logic                sop_o;
   logic                eop_o;
   logic                ready_out_i;
   logic [31:0]         frame_cnt_o;
   logic [15:0]         drop_cnt_o;

   modport slave (
      input  mac_src_i, mac_dst_i, data_i, empty_i, valid_i, sop_i, eop_i, ready_out_i,
      output ready_in_o, data_o, empty_o, valid_o, sop_o, eop_o, frame_cnt_o, drop_cnt_o
   );

   modport master (
      output mac_src_i, mac_dst_i, data_i, empty_i, valid_i, sop_i, eop_i, ready_out_i,
      input  ready_in_o, data_o, empty_o, valid_o, sop_o, eop_o, frame_cnt_o, drop_cnt_o
   );
endinterface

// File: rtl/avst_eth_framer.sv
// Ethernet framer on Avalon-ST: prepends dst MAC, src MAC and EtherType to a
// payload packet, realigns the payload behind the 14-byte header, and pads
// with zeros up to MIN_LEN bytes.
// Ports:
//   clk_sys_i   : system clock, rising edge
//   rst_sys_n_i : asynchronous active-low reset
//   bus         : avst_eth_framer_if.slave (payload in, frame out, counters)
module avst_eth_framer #(
   parameter int          DATA_W    = 32,
   parameter logic [15:0] ETHERTYPE = 16'h0800,
   parameter int          MIN_LEN   = 60
) (
   input  logic               clk_sys_i,
   input  logic               rst_sys_n_i,
   avst_eth_framer_if.slave   bus
);
   localparam int BYTES     = DATA_W / 8;
   localparam int EMPTY_W   = $clog2(BYTES);
   localparam int SHIFT     = 14 % BYTES;
   localparam int HDR_BEATS = 14 / BYTES;
   localparam int SH_W      = SHIFT * 8;
   localparam int TOP_W     = DATA_W - SH_W;
   localparam int TOP_BYTES = BYTES - SHIFT;

   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, FLUSH, PAD} state_t;

   state_t              state, state_n;
   logic                rdy_en;
   logic [111:0]        hdr, hdr_n;
   logic [1:0]          idx, idx_n;
   logic [15:0]         cnt, cnt_n;
   logic [SH_W-1:0]     carry, carry_n;
   logic [3:0]          left, left_n;
   logic [DATA_W-1:0]   data_q, data_n;
   logic [EMPTY_W-1:0]  empty_q, empty_n;
   logic                valid_q, valid_n, sop_q, sop_n, eop_q, eop_n;
   logic [31:0]         frame_q, frame_n;
   logic [15:0]         drop_q, drop_n;

   logic                rdy, out_adv, do_fin;
   logic [3:0]          fin_v, nin;
   logic [DATA_W-1:0]   fin_beat, beat;
   logic [16:0]         len, fin, lim;

   // Keeps the top nb bytes of a beat, zeroing the rest (stale or padding).
   function automatic logic [DATA_W-1:0] keep_mask(input logic [3:0] nb);
      logic [DATA_W-1:0] m;
      m = '1;
      if (nb < 4'(BYTES)) m = ~({DATA_W{1'b1}} >> (8 * nb));
      return m;
   endfunction

   always_comb begin
      state_n  = state;
      hdr_n    = hdr;
      idx_n    = idx;
      cnt_n    = cnt;
      carry_n  = carry;
      left_n   = left;
      data_n   = data_q;
      empty_n  = empty_q;
      valid_n  = valid_q;
      sop_n    = sop_q;
      eop_n    = eop_q;
      frame_n  = frame_q;
      drop_n   = drop_q;
      rdy      = 1'b0;
      do_fin   = 1'b0;
      fin_v    = '0;
      fin_beat = '0;
      nin      = 4'(BYTES) - 4'(bus.empty_i);
      beat     = {carry, bus.data_i[DATA_W-1 -: TOP_W]};
      len      = '0;
      fin      = '0;
      lim      = '0;
      // Output register may take a new beat when empty or being drained.
      out_adv  = ~valid_q | bus.ready_out_i;
      if (out_adv) valid_n = 1'b0;

      case (state)
         IDLE: begin
            rdy = rdy_en & ~bus.sop_i;
            if (bus.valid_i & rdy) begin
               if (drop_q != 16'hFFFF) drop_n = drop_q + 16'd1;
            end else if (bus.valid_i & bus.sop_i & rdy_en) begin
               // SOP beat is left in place; PAYLOAD consumes it.
               hdr_n   = {bus.mac_dst_i, bus.mac_src_i, ETHERTYPE};
               idx_n   = '0;
               cnt_n   = '0;
               state_n = HDR;
            end
         end
         HDR: if (out_adv) begin
            valid_n = 1'b1;
            data_n  = hdr[111 -: DATA_W];
            sop_n   = (idx == 2'd0);
            eop_n   = 1'b0;
            empty_n = '0;
            cnt_n   = cnt + 16'(BYTES);
            hdr_n   = hdr << DATA_W;
            idx_n   = idx + 2'd1;
            if (idx == 2'(HDR_BEATS - 1)) begin
               // Header bytes that do not fill a whole beat lead the payload.
               carry_n = hdr[111-DATA_W -: SH_W];
               state_n = PAYLOAD;
            end
         end
         PAYLOAD: begin
            rdy = rdy_en & bus.ready_out_i;
            if (bus.valid_i & rdy) begin
               carry_n = bus.data_i[SH_W-1:0];
               if (!bus.eop_i) begin
                  valid_n = 1'b1;
                  data_n  = beat;
                  sop_n   = 1'b0;
                  eop_n   = 1'b0;
                  empty_n = '0;
                  cnt_n   = cnt + 16'(BYTES);
               end else if (nin > 4'(TOP_BYTES)) begin
                  // Tail bytes spill past this beat: send a full beat now.
                  valid_n = 1'b1;
                  data_n  = beat;
                  sop_n   = 1'b0;
                  eop_n   = 1'b0;
                  empty_n = '0;
                  cnt_n   = cnt + 16'(BYTES);
                  left_n  = nin - 4'(TOP_BYTES);
                  state_n = FLUSH;
               end else begin
                  do_fin   = 1'b1;
                  fin_v    = 4'(SHIFT) + nin;
                  fin_beat = beat;
               end
            end
         end
         FLUSH: if (out_adv) begin
            do_fin   = 1'b1;
            fin_v    = left;
            fin_beat = {carry, {TOP_W{1'b0}}};
         end
         PAD: begin
            if (valid_q & eop_q) begin
               // Hold here until the final beat is taken.
               if (bus.ready_out_i) begin
                  frame_n = frame_q + 32'd1;
                  state_n = IDLE;
               end
            end else if (out_adv) begin
               do_fin = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Closing beat: fin_v data bytes, then zero padding up to MIN_LEN.
      // Either it ends the frame, or it is a full beat and PAD continues.
      if (do_fin) begin
         len     = 17'(cnt) + 17'(fin_v);
         fin     = (len < 17'(MIN_LEN)) ? 17'(MIN_LEN) : len;
         lim     = 17'(cnt) + 17'(BYTES);
         valid_n = 1'b1;
         sop_n   = 1'b0;
         data_n  = fin_beat & keep_mask(fin_v);
         state_n = PAD;
         if (fin <= lim) begin
            eop_n   = 1'b1;
            empty_n = EMPTY_W'(lim - fin);
         end else begin
            eop_n   = 1'b0;
            empty_n = '0;
            cnt_n   = cnt + 16'(BYTES);
         end
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
      if (!rst_sys_n_i) begin
         state   <= IDLE;
         rdy_en  <= 1'b0;
         hdr     <= '0;
         idx     <= '0;
         cnt     <= '0;
         carry   <= '0;
         left    <= '0;
         data_q  <= '0;
         empty_q <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         frame_q <= '0;
         drop_q  <= '0;
      end else begin
         state   <= state_n;
         rdy_en  <= 1'b1;
         hdr     <= hdr_n;
         idx     <= idx_n;
         cnt     <= cnt_n;
         carry   <= carry_n;
         left    <= left_n;
         data_q  <= data_n;
         empty_q <= empty_n;
         valid_q <= valid_n;
         sop_q   <= sop_n;
         eop_q   <= eop_n;
         frame_q <= frame_n;
         drop_q  <= drop_n;
      end
   end

   assign bus.ready_in_o  = rdy;
   assign bus.data_o      = data_q;
   assign bus.empty_o     = empty_q;
   assign bus.valid_o     = valid_q;
   assign bus.sop_o       = sop_q;
   assign bus.eop_o       = eop_q;
   assign bus.frame_cnt_o = frame_q;
   assign bus.drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_avst_eth_framer.sv
// Scoreboard bench for avst_eth_framer at DATA_W=32 and DATA_W=64.
module tb_avst_eth_framer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   avst_eth_framer_if #(.DATA_W(32)) b32();
   avst_eth_framer_if #(.DATA_W(64)) b64();

   avst_eth_framer #(.DATA_W(32)) dut32 (.clk_sys_i(clk), .rst_sys_n_i(rst_n), .bus(b32));
   avst_eth_framer #(.DATA_W(64)) dut64 (.clk_sys_i(clk), .rst_sys_n_i(rst_n), .bus(b64));

   typedef struct packed {
      logic [63:0] d;
      logic [2:0]  e;
      logic        s;
      logic        eo;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   int   checks = 0;
   int   errors = 0;
   int   beats32 = 0, beats64 = 0;
   int   last_e32 = -1, last_e64 = -1;
   logic stall32 = 1'b0;
   logic abort = 1'b0;
   logic drv_busy = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference frame: dst, src, EtherType 0x0800, payload, zero pad to 60.
   task automatic push_exp(input int W, input logic [47:0] dst, input logic [47:0] src,
                           input logic [7:0] pl[$]);
      logic [7:0] fb[$];
      exp_t x;
      int n, len, idx;
      for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fb.push_back(src[47-8*i -: 8]);
      fb.push_back(8'h08);
      fb.push_back(8'h00);
      foreach (pl[i]) fb.push_back(pl[i]);
      while (fb.size() < 60) fb.push_back(8'h00);
      len = fb.size();
      n = (len + W - 1) / W;
      for (int k = 0; k < n; k++) begin
         x = '0;
         for (int b = 0; b < W; b++) begin
            idx = k * W + b;
            if (idx < len) x.d[(W-1-b)*8 +: 8] = fb[idx];
         end
         x.s  = (k == 0);
         x.eo = (k == n - 1);
         x.e  = (k == n - 1) ? 3'((W - len % W) % W) : 3'd0;
         if (W == 4) q32.push_back(x); else q64.push_back(x);
      end
   endtask

   task automatic send(input int W, input logic [47:0] dst, input logic [47:0] src,
                       input logic [7:0] pl[$]);
      int n, len, tmo, idx;
      logic [63:0] d;
      logic acc, bail;
      drv_busy = 1'b1;
      bail = 1'b0;
      len = pl.size();
      n = (len + W - 1) / W;
      push_exp(W, dst, src, pl);
      if (W == 4) begin b32.mac_dst_i = dst; b32.mac_src_i = src; end
      else        begin b64.mac_dst_i = dst; b64.mac_src_i = src; end
      for (int k = 0; k < n && !abort && !bail; k++) begin
         d = {8{8'hEE}};
         for (int b = 0; b < W; b++) begin
            idx = k * W + b;
            if (idx < len) d[(W-1-b)*8 +: 8] = pl[idx];
         end
         if (W == 4) begin
            b32.data_i = d[31:0]; b32.sop_i = (k == 0); b32.eop_i = (k == n - 1);
            b32.empty_i = (k == n - 1) ? 2'((4 - len % 4) % 4) : 2'd0; b32.valid_i = 1'b1;
         end else begin
            b64.data_i = d; b64.sop_i = (k == 0); b64.eop_i = (k == n - 1);
            b64.empty_i = (k == n - 1) ? 3'((8 - len % 8) % 8) : 3'd0; b64.valid_i = 1'b1;
         end
         acc = 1'b0;
         tmo = 0;
         while (!acc && !abort && !bail) begin
            @(negedge clk);
            acc = (W == 4) ? b32.ready_in_o : b64.ready_in_o;
            @(posedge clk);
            #1;
            tmo++;
            if (tmo > 3000) begin
               checks++; errors++; bail = 1'b1;
               $display("FAIL input_timeout W=%0d beat=%0d got no ready want ready", W, k);
            end
         end
         // Header must come from the values latched at SOP.
         if (k == 0) begin
            if (W == 4) begin b32.mac_dst_i = 48'h0BAD0BAD0BAD; b32.mac_src_i = 48'h0; end
            else        begin b64.mac_dst_i = 48'h0BAD0BAD0BAD; b64.mac_src_i = 48'h0; end
         end
      end
      b32.valid_i = (W == 4) ? 1'b0 : b32.valid_i;
      b64.valid_i = (W == 8) ? 1'b0 : b64.valid_i;
      drv_busy = 1'b0;
   endtask

   task automatic drain(input int W);
      int tmo = 0;
      while (((W == 4) ? q32.size() : q64.size()) != 0) begin
         @(posedge clk);
         tmo++;
         if (tmo > 5000) begin
            checks++; errors++;
            $display("FAIL output_timeout W=%0d got %0d beats pending want 0", W,
                     (W == 4) ? q32.size() : q64.size());
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Downstream ready, optionally toggled at random.
   always begin
      @(posedge clk);
      #1;
      b32.ready_out_i = stall32 ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor 32: scoreboard pop plus stall stability.
   logic        st_v = 1'b0;
   logic [31:0] st_d;
   logic [1:0]  st_e;
   logic        st_s, st_p;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) st_v = 1'b0;
      else begin
         if (st_v) begin
            checks++;
            if (!b32.valid_o || b32.data_o !== st_d || b32.empty_o !== st_e ||
                b32.sop_o !== st_s || b32.eop_o !== st_p) begin
               errors++;
               $display("FAIL stall_hold got v=%b d=%h e=%0d want v=1 d=%h e=%0d",
                        b32.valid_o, b32.data_o, b32.empty_o, st_d, st_e);
            end
         end
         st_v = b32.valid_o && !b32.ready_out_i;
         st_d = b32.data_o; st_e = b32.empty_o; st_s = b32.sop_o; st_p = b32.eop_o;
         if (b32.valid_o && b32.ready_out_i) begin
            checks++;
            if (q32.size() == 0) begin
               errors++;
               $display("FAIL beat32 got unexpected d=%h want no beat", b32.data_o);
            end else begin
               e = q32.pop_front();
               if (b32.data_o !== e.d[31:0] || b32.empty_o !== e.e[1:0] ||
                   b32.sop_o !== e.s || b32.eop_o !== e.eo) begin
                  errors++;
                  $display("FAIL beat32 #%0d got d=%h e=%0d s=%b p=%b want d=%h e=%0d s=%b p=%b",
                           beats32, b32.data_o, b32.empty_o, b32.sop_o, b32.eop_o,
                           e.d[31:0], e.e[1:0], e.s, e.eo);
               end
            end
            beats32++;
            if (b32.eop_o) last_e32 = int'(b32.empty_o);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && b64.valid_o && b64.ready_out_i) begin
         checks++;
         if (q64.size() == 0) begin
            errors++;
            $display("FAIL beat64 got unexpected d=%h want no beat", b64.data_o);
         end else begin
            e = q64.pop_front();
            if (b64.data_o !== e.d || b64.empty_o !== e.e || b64.sop_o !== e.s ||
                b64.eop_o !== e.eo) begin
               errors++;
               $display("FAIL beat64 #%0d got d=%h e=%0d s=%b p=%b want d=%h e=%0d s=%b p=%b",
                        beats64, b64.data_o, b64.empty_o, b64.sop_o, b64.eop_o,
                        e.d, e.e, e.s, e.eo);
            end
         end
         beats64++;
         if (b64.eop_o) last_e64 = int'(b64.empty_o);
      end
   end

   function automatic void mkpl(output logic [7:0] pl[$], input int n, input int seed);
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(8'(i * 7 + seed));
   endfunction

   initial begin
      logic [7:0] pl[$];
      logic [47:0] dst, src;
      int b0, tmo;
      b32.mac_src_i = '0; b32.mac_dst_i = '0; b32.data_i = '0; b32.empty_i = '0;
      b32.valid_i = 1'b0; b32.sop_i = 1'b0; b32.eop_i = 1'b0; b32.ready_out_i = 1'b1;
      b64.mac_src_i = '0; b64.mac_dst_i = '0; b64.data_i = '0; b64.empty_i = '0;
      b64.valid_i = 1'b0; b64.sop_i = 1'b0; b64.eop_i = 1'b0; b64.ready_out_i = 1'b1;
      dst = 48'h001122334455;
      src = 48'hA0B1C2D3E4F5;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(b32.valid_o), 64'd0);
      chk("rst_ready", 64'(b32.ready_in_o), 64'd0);
      chk("rst_data", 64'(b32.data_o), 64'd0);
      chk("rst_frame", 64'(b32.frame_cnt_o), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_release", 64'(b32.ready_in_o), 64'd0);
      @(posedge clk);
      #1;
      chk("ready_one_cycle_later", 64'(b32.ready_in_o), 64'd1);

      // Two stray beats outside a packet are dropped.
      for (int i = 0; i < 2; i++) begin
         b32.data_i = 32'hDEAD0000 + 32'(i); b32.sop_i = 1'b0; b32.eop_i = 1'b1; b32.valid_i = 1'b1;
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      b32.valid_i = 1'b0;
      chk("drop_cnt", 64'(b32.drop_cnt_o), 64'd2);

      // 46-byte payload: exactly 60 bytes, no pad.
      mkpl(pl, 46, 3); b0 = beats32;
      send(4, dst, src, pl); drain(4);
      chk("f46_beats", 64'(beats32 - b0), 64'd15);
      chk("f46_empty", 64'(last_e32), 64'd0);
      chk("f46_frames", 64'(b32.frame_cnt_o), 64'd1);
      chk("drop_cnt_hold", 64'(b32.drop_cnt_o), 64'd2);

      // 1-byte payload AB, padded to 60.
      pl = {8'hAB}; b0 = beats32;
      send(4, dst, src, pl); drain(4);
      chk("f1_beats", 64'(beats32 - b0), 64'd15);
      chk("f1_empty", 64'(last_e32), 64'd0);

      // 2-byte payload in one beat carrying sop and eop.
      pl = {8'h5A, 8'hC3}; b0 = beats32;
      send(4, src, dst, pl); drain(4);
      chk("f2_beats", 64'(beats32 - b0), 64'd15);

      // 47 bytes: 61 total, first length past MIN_LEN.
      mkpl(pl, 47, 11); b0 = beats32;
      send(4, dst, src, pl); drain(4);
      chk("f47_beats", 64'(beats32 - b0), 64'd16);
      chk("f47_empty", 64'(last_e32), 64'd3);

      // 51 bytes: flush beat needed.
      mkpl(pl, 51, 1); b0 = beats32;
      send(4, dst, src, pl); drain(4);
      chk("f51_beats", 64'(beats32 - b0), 64'd17);
      chk("f51_empty", 64'(last_e32), 64'd3);

      // 100 bytes, without and then with random backpressure.
      mkpl(pl, 100, 5); b0 = beats32;
      send(4, dst, src, pl); drain(4);
      chk("f100_beats", 64'(beats32 - b0), 64'd29);
      chk("f100_empty", 64'(last_e32), 64'd2);
      stall32 = 1'b1; b0 = beats32;
      send(4, dst, src, pl); drain(4);
      stall32 = 1'b0;
      chk("f100s_beats", 64'(beats32 - b0), 64'd29);
      chk("frames_after_7", 64'(b32.frame_cnt_o), 64'd7);

      // 64-bit width, 51 bytes.
      mkpl(pl, 51, 1); b0 = beats64;
      send(8, dst, src, pl); drain(8);
      chk("w64_beats", 64'(beats64 - b0), 64'd9);
      chk("w64_empty", 64'(last_e64), 64'd7);
      chk("w64_frames", 64'(b64.frame_cnt_o), 64'd1);

      // Reset while the 5th output beat is presented.
      mkpl(pl, 46, 9); b0 = beats32;
      fork
         send(4, dst, src, pl);
      join_none
      tmo = 0;
      do begin
         @(negedge clk);
         #1;
         tmo++;
      end while (!(beats32 >= b0 + 4 && b32.valid_o) && tmo < 500);
      if (tmo >= 500) begin
         checks++; errors++;
         $display("FAIL fifth_beat_wait got %0d beats want 4", beats32 - b0);
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(b32.valid_o), 64'd0);
      chk("midrst_sop_eop", 64'({b32.sop_o, b32.eop_o}), 64'd0);
      chk("midrst_data", 64'(b32.data_o), 64'd0);
      chk("midrst_empty", 64'(b32.empty_o), 64'd0);
      chk("midrst_ready", 64'(b32.ready_in_o), 64'd0);
      chk("midrst_frames", 64'(b32.frame_cnt_o), 64'd0);
      chk("midrst_drops", 64'(b32.drop_cnt_o), 64'd0);
      abort = 1'b1;
      tmo = 0;
      while (drv_busy && tmo < 100) begin @(posedge clk); tmo++; end
      q32.delete();
      b32.valid_i = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      abort = 1'b0;
      mkpl(pl, 46, 21); b0 = beats32;
      send(4, src, dst, pl); drain(4);
      chk("postrst_beats", 64'(beats32 - b0), 64'd15);
      chk("postrst_frames", 64'(b32.frame_cnt_o), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
